// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the CPU byte-bus target:
// I/O address map, region decode and the bus request bundle.
package mem_bus_responder_pkg;

    localparam logic [17:0] IO_PORT_ADDR  = 18'h30000;
    localparam logic [17:0] IO_CLOCK_ADDR = 18'h30004;
    localparam logic [1:0]  IO_SEL        = IO_PORT_ADDR[17:16];

    localparam logic [2:0] IO_PORT_OFS  = IO_PORT_ADDR[2:0];
    localparam logic [2:0] IO_CLOCK_OFS = IO_CLOCK_ADDR[2:0];

    typedef enum logic [1:0] {
        RGN_RAM0 = 2'b00,
        RGN_RAM1 = 2'b01,
        RGN_VOID = 2'b10,
        RGN_IO   = IO_SEL
    } region_e;

    typedef struct packed {
        logic [17:0] addr;
        logic        wr;
        logic [7:0]  data;
    } bus_req_t;

    function automatic region_e decode_region(input logic [17:0] a);
        return region_e'(a[17:16]);
    endfunction

    function automatic logic [7:0] le_byte(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_bus_responder_byte_fifo.sv
// Byte FIFO used for both host-facing ports.
// Push when full and pop when empty are ignored; empty head reads 0x00.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = CW - 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Target end of the CPU byte-wide memory bus: RAM plus an I/O window
// with RX/TX byte FIFOs, a free-running cycle counter and a halt flag.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int    RAM_AW     = 17,
    parameter int    FIFO_DEPTH = 8,
    parameter string INIT_FILE  = "test.data"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic        tx_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_req_t          req;
    region_e           rgn;
    logic [2:0]        ofs;
    logic              is_ram;
    logic              is_io;
    logic              bus_rd;
    logic              bus_wr;

    logic [7:0]        ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;

    logic [31:0]       cycle_cnt;
    logic [31:0]       snap;
    logic              clk_rd;
    logic              halt_wr;
    logic [7:0]        io_rd;
    logic [7:0]        rd_data;

    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [7:0]        rx_head;
    logic [CW-1:0]     rx_count;

    logic              tx_push;
    logic [7:0]        tx_byte;
    logic              tx_full;
    logic              tx_empty;
    logic [CW-1:0]     tx_count;

    logic              unused_ok;

    assign req     = '{addr: mem_a[17:0], wr: mem_wr, data: mem_dout};
    assign rgn     = decode_region(req.addr);
    assign ofs     = req.addr[2:0];
    assign ram_idx = req.addr[RAM_AW-1:0];
    assign is_ram  = (rgn == RGN_RAM0) || (rgn == RGN_RAM1);
    assign is_io   = (rgn == RGN_IO);
    assign bus_rd  = rdy && !req.wr;
    assign bus_wr  = rdy && req.wr;

    assign rx_pop  = bus_rd && is_io && (ofs == IO_PORT_OFS);
    assign clk_rd  = bus_rd && is_io && (ofs == IO_CLOCK_OFS);
    assign halt_wr = bus_wr && is_io && (ofs == IO_CLOCK_OFS);

    // A zero byte on the port is dropped; the halt write emits the terminator.
    assign tx_push = halt_wr
                  || (bus_wr && is_io && (ofs == IO_PORT_OFS)
                      && (req.data != 8'h00));
    assign tx_byte = halt_wr ? 8'h00 : req.data;

    always_comb begin
        io_rd = 8'h00;
        unique case (1'b1)
            ofs == IO_PORT_OFS:
                io_rd = rx_head;
            ofs == IO_CLOCK_OFS:
                io_rd = cycle_cnt[7:0];
            ofs[2] && (ofs[1:0] != 2'b00):
                io_rd = le_byte(snap, ofs[1:0]);
            default: ;
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        unique case (1'b1)
            is_ram:  rd_data = ram[ram_idx];
            is_io:   rd_data = io_rd;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset && bus_wr && is_ram)
            ram[ram_idx] <= req.data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_din     <= 8'h00;
            halt        <= 1'b0;
            tx_overflow <= 1'b0;
            cycle_cnt   <= '0;
            snap        <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bus_rd)
                mem_din <= rd_data;
            // Later bytes of the dword come from this copy, not the live count.
            if (clk_rd)
                snap <= cycle_cnt;
            if (halt_wr)
                halt <= 1'b1;
            if (tx_push && tx_full)
                tx_overflow <= 1'b1;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .din   (tx_byte),
        .pop   (tx_ready),
        .head  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign rx_ready  = !rx_full;
    assign tx_valid  = !tx_empty;
    assign unused_ok = ^{mem_a[31:18], rx_empty, rx_count, tx_count};

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: directed scenarios then
// randomized bus/host traffic against a queue-based reference model.
module tb_mem_bus_responder;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rdy = 1'b0;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  mem_din;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic        tx_overflow;

    always #5 clock = ~clock;

    mem_bus_responder #(
        .RAM_AW     (17),
        .FIFO_DEPTH (DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rdy         (rdy),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .halt        (halt),
        .tx_overflow (tx_overflow)
    );

    int nvec = 0;
    int nbad = 0;

    int               exp_rd[$];
    byte unsigned     rxq[$];
    byte unsigned     txq[$];
    byte unsigned     ram_m[int];
    int unsigned      m_cnt = 0;
    int unsigned      m_snap = 0;
    bit               m_halt = 0;
    bit               m_ovf = 0;
    bit               started = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference model: bus effects computed from the address map rules.
    logic [1:0]   m_sel;
    int           m_ofs;
    int           m_ra;
    int           m_rxn;
    int           m_txn;
    int           m_e;
    bit           m_take;
    bit           m_put;
    byte unsigned m_txb;

    always @(posedge clock) begin
        if (reset) begin
            rxq.delete();
            txq.delete();
            exp_rd.delete();
            exp_rd.push_back(0);
            m_cnt   = 0;
            m_snap  = 0;
            m_halt  = 0;
            m_ovf   = 0;
            started = 1;
        end else begin
            m_sel  = mem_a[17:16];
            m_ofs  = int'(mem_a[2:0]);
            m_ra   = int'(mem_a[16:0]);
            m_rxn  = rxq.size();
            m_txn  = txq.size();
            m_take = 0;
            m_put  = 0;
            m_txb  = 0;
            if (rdy && !mem_wr) begin
                m_e = 0;
                if (!m_sel[1])
                    m_e = ram_m.exists(m_ra) ? int'(ram_m[m_ra]) : -1;
                else if (m_sel == 2'b11) begin
                    case (m_ofs)
                        0: begin
                            m_e    = (m_rxn > 0) ? int'(rxq[0]) : 0;
                            m_take = (m_rxn > 0);
                        end
                        4: begin
                            m_e    = int'(m_cnt % 256);
                            m_snap = m_cnt;
                        end
                        5, 6, 7: m_e = int'((m_snap >> (8 * (m_ofs - 4))) % 256);
                        default: m_e = 0;
                    endcase
                end
                exp_rd.push_back(m_e);
            end
            if (rdy && mem_wr) begin
                if (!m_sel[1])
                    ram_m[m_ra] = mem_dout;
                else if (m_sel == 2'b11 && m_ofs == 0 && mem_dout != 0) begin
                    m_put = 1;
                    m_txb = mem_dout;
                end else if (m_sel == 2'b11 && m_ofs == 4) begin
                    m_put  = 1;
                    m_txb  = 0;
                    m_halt = 1;
                end
            end
            if (m_txn > 0 && tx_ready)
                void'(txq.pop_front());
            if (m_put) begin
                if (m_txn == DEPTH)
                    m_ovf = 1;
                else
                    txq.push_back(m_txb);
            end
            if (m_take)
                void'(rxq.pop_front());
            if (rx_valid && m_rxn < DEPTH)
                rxq.push_back(rx_data);
            m_cnt = m_cnt + 1;
        end
    end

    // Monitor: compare DUT outputs against the scoreboard between edges.
    int mon_e;

    always @(negedge clock) begin
        if (started) begin
            if (exp_rd.size() > 0) begin
                mon_e = exp_rd.pop_front();
                if (mon_e >= 0)
                    check("mem_din", 32'(mem_din), 32'(mon_e));
            end
            check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
            if (txq.size() != 0)
                check("tx_data", 32'(tx_data), 32'(txq[0]));
            check("rx_ready", 32'(rx_ready), 32'(rxq.size() < DEPTH));
            check("halt", 32'(halt), 32'(m_halt));
            check("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
        end
    end

    task automatic cyc(input bit r, input logic [31:0] a, input bit w,
                       input logic [7:0] d);
        rdy      = r;
        mem_a    = a;
        mem_wr   = w;
        mem_dout = d;
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 8'h00);
    endtask

    logic [31:0] r_hi;
    logic [31:0] r_a;
    logic [7:0]  r_d;
    bit          r_w;
    bit          r_r;
    int          r_k;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // RAM write then read-back
        cyc(1, 32'h10, 1, 8'hA5);
        cyc(1, 32'h10, 0, 8'h00);
        check("t1_ram_rd", 32'(mem_din), 32'hA5);

        // RX FIFO drained by port reads
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        idle();
        rx_data  = 8'h42;
        idle();
        rx_valid = 1'b0;
        cyc(1, 32'h30000, 0, 8'h00);
        check("t2_rx0", 32'(mem_din), 32'h41);
        cyc(1, 32'h30000, 0, 8'h00);
        check("t2_rx1", 32'(mem_din), 32'h42);
        cyc(1, 32'h30000, 0, 8'h00);
        check("t2_rx_empty", 32'(mem_din), 32'h00);

        // TX: zero dropped, nonzero held until consumed
        tx_ready = 1'b0;
        cyc(1, 32'h30000, 1, 8'h00);
        check("t3_zero_drop", 32'(tx_valid), 32'h0);
        cyc(1, 32'h30000, 1, 8'h48);
        check("t3_valid", 32'(tx_valid), 32'h1);
        idle();
        idle();
        check("t3_hold", 32'(tx_data), 32'h48);
        tx_ready = 1'b1;
        idle();
        check("t3_pop", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Coherent counter read across a byte carry
        for (int i = 0; i < 2000 && m_cnt != 32'h2FF; i++)
            idle();
        check("t4_reach", m_cnt, 32'h2FF);
        cyc(1, 32'h30004, 0, 8'h00);
        check("t4_b0", 32'(mem_din), 32'hFF);
        cyc(1, 32'h30005, 0, 8'h00);
        check("t4_b1", 32'(mem_din), 32'h02);
        cyc(1, 32'h30006, 0, 8'h00);
        check("t4_b2", 32'(mem_din), 32'h00);
        cyc(1, 32'h30007, 0, 8'h00);
        check("t4_b3", 32'(mem_din), 32'h00);

        // Halt write, then reset clears it
        cyc(1, 32'h30004, 1, 8'h77);
        check("t5_halt", 32'(halt), 32'h1);
        check("t5_nul", 32'(tx_data), 32'h00);
        check("t5_nul_v", 32'(tx_valid), 32'h1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("t5_halt_clr", 32'(halt), 32'h0);
        check("t5_tx_clr", 32'(tx_valid), 32'h0);
        cyc(1, 32'h30004, 0, 8'h00);
        check("t5_cnt0", 32'(mem_din), 32'h00);

        // TX overflow on the ninth byte
        for (int i = 1; i <= 9; i++)
            cyc(1, 32'h30000, 1, 8'(i));
        check("t6_ovf", 32'(tx_overflow), 32'h1);
        tx_ready = 1'b1;
        repeat (DEPTH) idle();
        check("t6_drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // rdy low blocks the RAM write
        cyc(1, 32'h20, 1, 8'h5A);
        cyc(0, 32'h20, 1, 8'hC3);
        cyc(1, 32'h20, 0, 8'h00);
        check("t6_rdy0", 32'(mem_din), 32'h5A);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 399) == 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) == 0);
            r_r      = ($urandom_range(0, 9) != 0);
            r_hi     = $urandom & 32'hFFFC0000;
            r_k      = $urandom_range(0, 15);
            r_d      = 8'($urandom);
            r_w      = 1'b0;
            r_a      = r_hi | 32'h20000;
            case (r_k)
                0, 1, 2, 3, 4, 5: begin
                    r_a = r_hi | ($urandom_range(0, 1) << 16)
                               | $urandom_range(0, 31);
                    r_w = (r_k < 3);
                end
                6, 7: r_a = r_hi | 32'h30000;
                8, 9: begin
                    r_a = r_hi | 32'h30000;
                    r_w = 1'b1;
                    if ($urandom_range(0, 3) == 0)
                        r_d = 8'h00;
                end
                10, 11: r_a = r_hi | 32'h30004 | $urandom_range(0, 3);
                12: begin
                    r_a = r_hi | 32'h20000 | $urandom_range(0, 16'hFFFF);
                    r_w = 1'($urandom_range(0, 1));
                end
                13: begin
                    r_a = r_hi | 32'h30000 | $urandom_range(1, 3);
                    r_w = 1'($urandom_range(0, 1));
                end
                14: if ($urandom_range(0, 9) == 0) begin
                    r_a = r_hi | 32'h30004;
                    r_w = 1'b1;
                end
                default: ;
            endcase
            cyc(r_r, r_a, r_w, r_d);
        end

        reset    = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (4) idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
